// File: rtl/seg_display_if.sv
// Bus bundle between a display data source and seg_display_scanner.
interface seg_display_if #(
    parameter int unsigned NUM_DIGITS = 8
);
    logic                      enable;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   data_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [6:0]                seg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_done;
    logic                      pending;

    modport master (
        output enable, load, data_in, dp_in,
        input  seg, dp, an, frame_done, pending
    );

    modport slave (
        input  enable, load, data_in, dp_in,
        output seg, dp, an, frame_done, pending
    );
endinterface

// File: rtl/seg_display_scanner.sv
// Multiplexed common-anode 7-segment scanner with double-buffered frame updates.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_display_scanner #(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_display_if.slave  bus
);
    localparam int unsigned DATA_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]     pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pending_q, pending_d;
    logic [DATA_W-1:0]     shad_data_q, shad_data_d;
    logic [NUM_DIGITS-1:0] shad_dp_q, shad_dp_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  wrap_q;
    logic                  frame_done_q;

    logic                  tick;
    logic                  wrap;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic [NUM_DIGITS-1:0] blank_mask;

    function automatic logic [6:0] decode_hex(input logic [3:0] nib);
        case (nib)
            4'h0:    decode_hex = 7'b0000001;
            4'h1:    decode_hex = 7'b1001111;
            4'h2:    decode_hex = 7'b0010010;
            4'h3:    decode_hex = 7'b0000110;
            4'h4:    decode_hex = 7'b1001100;
            4'h5:    decode_hex = 7'b0100100;
            4'h6:    decode_hex = 7'b0100000;
            4'h7:    decode_hex = 7'b0001111;
            4'h8:    decode_hex = 7'b0000000;
            4'h9:    decode_hex = 7'b0000100;
            4'hA:    decode_hex = 7'b0001000;
            4'hB:    decode_hex = 7'b1100000;
            4'hC:    decode_hex = 7'b0110001;
            4'hD:    decode_hex = 7'b1000010;
            4'hE:    decode_hex = 7'b0110000;
            default: decode_hex = 7'b0111000;
        endcase
    endfunction

    assign tick = bus.enable && (cnt_q == CNT_MAX);
    assign wrap = tick && (idx_q == IDX_MAX);

    // Prescaler and digit index; both parked at zero while disabled.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!bus.enable) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (tick) begin
            cnt_d = '0;
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Double buffer: a load lands in shadow only at a frame wrap.
    always_comb begin
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pending_d   = pending_q;
        shad_data_d = shad_data_q;
        shad_dp_d   = shad_dp_q;
        if (wrap) begin
            pending_d = 1'b0;
            if (bus.load) begin
                shad_data_d = bus.data_in;
                shad_dp_d   = bus.dp_in;
            end else if (pending_q) begin
                shad_data_d = pend_data_q;
                shad_dp_d   = pend_dp_q;
            end
        end else if (bus.load) begin
            pend_data_d = bus.data_in;
            pend_dp_d   = bus.dp_in;
            pending_d   = 1'b1;
        end
    end

`ifdef SEG_SCAN_LZB_EN
    logic lzb_zero;

    // A digit blanks when it and every more-significant nibble are zero.
    always_comb begin
        blank_mask = '0;
        lzb_zero   = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
            lzb_zero      = lzb_zero && (shad_data_q[4*k +: 4] == 4'h0);
            blank_mask[k] = lzb_zero;
        end
    end
`else
    assign blank_mask = '0;
`endif

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib   = shad_data_q[4*k +: 4];
                cur_dp    = shad_dp_q[k];
                cur_blank = blank_mask[k];
            end
        end
    end

    always_comb begin
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        an_d  = '1;
        if (bus.enable) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            dp_d  = ~cur_dp;
            seg_d = cur_blank ? 7'h7F : decode_hex(cur_nib);
        end
    end

    // frame_done is delayed one extra stage so it coincides with digit 0 on the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pending_q    <= 1'b0;
            shad_data_q  <= '0;
            shad_dp_q    <= '0;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            an_q         <= '1;
            wrap_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pending_q    <= pending_d;
            shad_data_q  <= shad_data_d;
            shad_dp_q    <= shad_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            wrap_q       <= wrap;
            frame_done_q <= wrap_q;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;
    assign bus.pending    = pending_q;
endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner: frame-position model plus directed literal checks.
module tb_seg_display_scanner;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam int FR = ND * RD;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        ld    = 1'b0;
    logic [15:0] din   = 16'h0;
    logic [3:0]  dpin  = 4'h0;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    seg_display_if #(.NUM_DIGITS(ND)) bus ();

    assign bus.enable  = en;
    assign bus.load    = ld;
    assign bus.data_in = din;
    assign bus.dp_in   = dpin;

    seg_display_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    // Expected segments for digit d of a displayed word.
    function automatic logic [6:0] exp_seg(input logic [15:0] word, input int d);
        logic [15:0] hi;
        hi = word >> (4 * d);
`ifdef SEG_SCAN_LZB_EN
        if (d > 0 && hi == 16'h0) return 7'h7F;
`endif
        return hex7(hi[3:0]);
    endfunction

    // Model: a flat position within the frame plus displayed/waiting words.
    int          m_pos;
    int          dig;
    logic [15:0] m_shadow, m_pval;
    logic [3:0]  m_sdp, m_pdp;
    logic        m_pend, m_prev_wrap, m_wrap;
    logic        s_en, s_ld;
    logic [15:0] s_d;
    logic [3:0]  s_p;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd, e_pend;

    always @(posedge clk) begin
        s_en = en; s_ld = ld; s_d = din; s_p = dpin;
        if (!rst_n) begin
            m_pos = 0; m_shadow = '0; m_sdp = '0; m_pval = '0; m_pdp = '0;
            m_pend = 1'b0; m_prev_wrap = 1'b0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0; e_pend = 1'b0;
        end else begin
            dig = m_pos / RD;
            if (s_en) begin
                e_an  = ~(4'b0001 << dig);
                e_seg = exp_seg(m_shadow, dig);
                e_dp  = ~m_sdp[dig];
            end else begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end
            e_fd   = m_prev_wrap;
            m_wrap = s_en && (m_pos == FR - 1);
            if (m_wrap) begin
                if (s_ld) begin
                    m_shadow = s_d; m_sdp = s_p;
                end else if (m_pend) begin
                    m_shadow = m_pval; m_sdp = m_pdp;
                end
                m_pend = 1'b0;
            end else if (s_ld) begin
                m_pval = s_d; m_pdp = s_p; m_pend = 1'b1;
            end
            m_pos       = s_en ? (m_pos + 1) % FR : 0;
            m_prev_wrap = m_wrap;
            e_pend      = m_pend;
        end
        #1;
        chk("model_an", 32'(bus.an), 32'(e_an));
        chk("model_seg", 32'(bus.seg), 32'(e_seg));
        chk("model_dp", 32'(bus.dp), 32'(e_dp));
        chk("model_frame_done", 32'(bus.frame_done), 32'(e_fd));
        chk("model_pending", 32'(bus.pending), 32'(e_pend));
    end

    task automatic step_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        while (n < 64) begin
            @(posedge clk);
            #1;
            if (bus.frame_done) break;
            n++;
        end
        chk("frame_done_seen", 32'(bus.frame_done), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        @(negedge clk);
        ld = 1'b1; din = d; dpin = p;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic chk_digit(input string name, input logic [3:0] an_e, input logic [6:0] seg_e);
        chk({name, "_an"}, 32'(bus.an), 32'(an_e));
        chk({name, "_seg"}, 32'(bus.seg), 32'(seg_e));
    endtask

    logic [6:0] lzb_zero_seg;

    initial begin
`ifdef SEG_SCAN_LZB_EN
        lzb_zero_seg = 7'h7F;
`else
        lzb_zero_seg = 7'b0000001;
`endif
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(bus.an), 32'hF);
        chk("rst_seg", 32'(bus.seg), 32'h7F);
        chk("rst_dp", 32'(bus.dp), 32'd1);
        chk("rst_pending", 32'(bus.pending), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);

        @(negedge clk);
        rst_n = 1'b1; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step_pos();
            chk_digit("first_digit0", 4'b1110, 7'b0000001);
        end
        step_pos();
        chk_digit("first_digit1", 4'b1101, 7'b0000001);

        // Mid-frame load appears only after the wrap.
        do_load(16'h12AF, 4'b0100);
        step_pos();
        chk("scan_pending_set", 32'(bus.pending), 32'd1);
        chk_digit("scan_not_torn", 4'b1101, 7'b0000001);
        wait_fd();
        chk("scan_pending_clr", 32'(bus.pending), 32'd0);
        chk_digit("scan_d0", 4'b1110, 7'b0111000);
        chk("scan_d0_dp", 32'(bus.dp), 32'd1);
        repeat (4) step_pos();
        chk_digit("scan_d1", 4'b1101, 7'b0001000);
        repeat (4) step_pos();
        chk_digit("scan_d2", 4'b1011, 7'b0010010);
        chk("scan_d2_dp", 32'(bus.dp), 32'd0);
        repeat (4) step_pos();
        chk_digit("scan_d3", 4'b0111, 7'b1001111);
        repeat (4) step_pos();
        chk("fd_period", 32'(bus.frame_done), 32'd1);

        // Load on the exact wrap edge goes straight to the display.
        repeat (14) step_pos();
        @(negedge clk);
        ld = 1'b1; din = 16'h0003; dpin = 4'b0000;
        @(negedge clk);
        ld = 1'b0;
        step_pos();
        chk("simul_fd", 32'(bus.frame_done), 32'd1);
        chk_digit("simul_d0", 4'b1110, 7'b0000110);
        chk("simul_pending", 32'(bus.pending), 32'd0);

        do_load(16'h1111, 4'b0000);
        repeat (2) step_pos();
        do_load(16'h2222, 4'b0000);
        wait_fd();
        chk_digit("twoload_d0", 4'b1110, 7'b0010010);
        repeat (4) step_pos();
        chk_digit("twoload_d1", 4'b1101, 7'b0010010);

        // Disable mid-frame: blank, still accept loads, resume at digit 0.
        repeat (2) step_pos();
        @(negedge clk);
        en = 1'b0;
        step_pos();
        chk_digit("dis_blank", 4'b1111, 7'h7F);
        chk("dis_dp", 32'(bus.dp), 32'd1);
        do_load(16'h5678, 4'b0001);
        step_pos();
        chk("dis_pending", 32'(bus.pending), 32'd1);
        repeat (20) step_pos();
        chk("dis_pending_hold", 32'(bus.pending), 32'd1);
        @(negedge clk);
        en = 1'b1;
        step_pos();
        chk_digit("reen_d0", 4'b1110, 7'b0010010);
        wait_fd();
        chk("reen_pending_clr", 32'(bus.pending), 32'd0);
        chk_digit("reen_new_d0", 4'b1110, 7'b0000000);
        chk("reen_new_dp", 32'(bus.dp), 32'd0);

        // Leading zeros: blanked only when blanking is compiled in.
        do_load(16'h0040, 4'b0000);
        wait_fd();
        chk_digit("lz40_d0", 4'b1110, 7'b0000001);
        repeat (4) step_pos();
        chk_digit("lz40_d1", 4'b1101, 7'b1001100);
        repeat (4) step_pos();
        chk_digit("lz40_d2", 4'b1011, lzb_zero_seg);
        repeat (4) step_pos();
        chk_digit("lz40_d3", 4'b0111, lzb_zero_seg);
        do_load(16'h0000, 4'b0000);
        wait_fd();
        chk_digit("lz00_d0", 4'b1110, 7'b0000001);
        repeat (4) step_pos();
        chk_digit("lz00_d1", 4'b1101, lzb_zero_seg);

        // Reset mid-frame discards pending data.
        do_load(16'hABCD, 4'b1111);
        @(negedge clk);
        rst_n = 1'b0;
        step_pos();
        chk_digit("midrst", 4'b1111, 7'h7F);
        chk("midrst_pending", 32'(bus.pending), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fd();
        chk_digit("midrst_d0", 4'b1110, 7'b0000001);
        chk("midrst_dp", 32'(bus.dp), 32'd1);
        repeat (3) step_pos();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seg_display_scanner.md
# seg_display_scanner

Time-multiplexed driver for a common-anode multi-digit 7-segment display. It accepts a packed hex word and per-digit decimal points, and scans one digit at a time at a programmable refresh rate. Updates are double-buffered, so a new value only appears at a frame boundary and frames never tear. It sits between the UART data path (or debug registers) and the board display pins, and replaces per-digit static decoding where the board shares segment lines.

## Interface
- `NUM_DIGITS`, 8, number of digits scanned; must be ≥ 1.
- `REFRESH_DIV`, 100000, clock cycles each digit stays lit; must be ≥ 2.

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `enable`  in  1  scanning enabled; low blanks the display
- `load`  in  1  single-cycle request to capture `data_in`/`dp_in`
- `data_in`  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k, with digit 0 at the LSBs
- `dp_in`  in  NUM_DIGITS  decimal point request per digit, active-high
- `seg`  out  7  segments {a,b,c,d,e,f,g}, where seg[6]=a; active-low
- `dp`  out  1  decimal point, active-low
- `an`  out  NUM_DIGITS  digit anodes, active-low, one-hot-low when lit
- `frame_done`  out  1  one-cycle pulse at each frame wrap
- `pending`  out  1  a loaded value is waiting for the next frame boundary

## Operation
- Prescaler `cnt` counts 0..REFRESH_DIV-1. `tick` = enable && cnt==REFRESH_DIV-1. On tick, cnt goes to 0 and digit index `idx` advances; idx wraps from NUM_DIGITS-1 to 0.
- `wrap` = tick && idx==NUM_DIGITS-1.
- Pending buffer:
  - `load` captures `data_in`/`dp_in` into the pending register and sets `pending`. A later load before the wrap overwrites the earlier one.
  - On wrap, the pending value is copied to the shadow register and `pending` clears.
  - If load and wrap occur in the same cycle, `data_in`/`dp_in` are written directly to shadow and `pending` is 0 afterwards.
- Decode uses shadow nibble[idx], active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- `an` = ~(1<<idx). `dp` = ~shadow_dp[idx].
- enable low:
  - cnt and idx are forced to 0.
  - an, seg and dp are all ones.
  - The pending buffer still accepts loads. No wrap occurs, so `pending` holds.
- NUM_DIGITS=1: idx is constant 0 and every tick is a wrap.

## Timing
- Reset (async assert, sync release) sets: an all ones, seg=7'h7F, dp=1, frame_done=0, pending=0, cnt=0, idx=0, pending and shadow registers all zero.
- seg, dp, an and frame_done are registered: each reflects state from the previous cycle, so latency is 1 clock.
- Each digit is lit for exactly REFRESH_DIV cycles. A frame lasts NUM_DIGITS*REFRESH_DIV cycles.
- frame_done is high for the single cycle immediately after the wrap edge. an selects digit 0 on that same cycle.
- After a load, new data is visible from the first cycle digit 0 is displayed after the next wrap. It is never visible mid-frame.
- enable rising: digit 0 is shown from the cycle after the first enabled edge, and the first tick occurs REFRESH_DIV-1 cycles later.
- Reset mid-frame aborts the scan and discards any pending data.

## Configuration
- `SEG_SCAN_LZB_EN` defined: leading-zero blanking.
  - Digit k>0 shows seg=7'h7F when its nibble and all higher nibbles in shadow are 0.
  - Digit 0 is never blanked.
  - dp is unaffected by blanking.
- Not defined: every digit always shows its decoded nibble.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4.
- Reset checks:
  - Reset -> an=4'b1111, seg=7'h7F, dp=1, pending=0.
  - After release with enable=1 -> an=4'b1110 and seg=7'b0000001, each held for 4 cycles.
- Scan sequence:
  - Stimulus: load data_in=16'h12AF, dp_in=4'b0100 mid-frame.
  - pending=1 until the next wrap.
  - The frame after the wrap shows:
    - an=1110 with seg=0111000 (F)
    - an=1101 with seg=0001000 (A)
    - an=1011 with seg=0010010 (2) and dp=0
    - an=0111 with seg=1001111 (1)
  - frame_done pulses every 16 cycles.
- Simultaneous load/wrap:
  - Load 16'h0003 on the wrap cycle -> the next frame shows 3 on digit 0, and pending stays 0.
  - Two loads in one frame (16'h1111 then 16'h2222) -> only 2222 is displayed.
- Enable low mid-frame:
  - Outputs are all ones after 1 cycle; a load during this time sets pending.
  - On re-enable, digit 0 is shown and pending clears at the first wrap.
- With `SEG_SCAN_LZB_EN`:
  - data 16'h0040 -> digits 3 and 2 show 7'h7F, digit 1 shows 4, digit 0 shows 0.
  - data 16'h0000 -> only digit 0 is lit with 0.
